ram_stream_reader: RTL

- Read-side master for the 4096x8 single-clock RAM (synchronous read, 1-cycle latency, `q` registered).
- On a start command, it fetches a contiguous block of LENGTH bytes from START_ADDR, wrapping at the top of memory.
- It delivers the bytes in order on a valid/ready byte stream to downstream consumers (UART TX, display shifter).
- It absorbs RAM read latency and downstream backpressure with an internal 2-entry skid buffer, so no byte is lost or duplicated.

---
 rtl/ram_stream_reader.sv | 83 ++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: streams a contiguous, address-wrapping block of RAM bytes through a 2-entry skid buffer
module ram_stream_reader #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] read_address,
    input  logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr, r_raddr;
    logic [ADDR_W:0]   r_remaining;
    logic              r_inflight;
    logic [DATA_W-1:0] r_buf [2];
    logic              r_wr_ptr, r_rd_ptr;
    logic [1:0]        r_count;
    logic              w_pop, w_issue, w_last;
    logic [1:0]        w_occ_after, w_next;
    always_comb begin
        w_pop       = out_valid && out_ready;
        w_occ_after = r_count - {1'b0, w_pop};
        w_issue     = r_state == RUN && r_remaining != '0 && (w_occ_after + {1'b0, r_inflight}) <= 2'd1;
        w_last      = r_remaining == '0 && !r_inflight;
        w_next      = r_state == IDLE  ? (start ? (length == '0 ? DONE : RUN) : IDLE)
                    : r_state == RUN   ? (w_last ? (w_occ_after == '0 ? DONE : DRAIN) : RUN)
                    : r_state == DRAIN ? (w_occ_after == '0 ? DONE : DRAIN)
                    : IDLE;
    end
    assign busy         = r_state == RUN || r_state == DRAIN;
    assign done         = r_state == DONE;
    assign read_address = w_issue ? r_addr : r_raddr;
    assign out_valid    = r_count != 2'd0;
    assign out_data     = r_buf[r_rd_ptr];
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_addr      <= '0;
            r_raddr     <= '0;
            r_remaining <= '0;
            r_inflight  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_inflight <= w_issue;
            if (r_state == IDLE && start) begin
                r_addr      <= start_addr;
                r_remaining <= length;
            end
            if (w_issue) begin
                r_raddr     <= r_addr;
                r_addr      <= r_addr + ADDR_W'(1);
                r_remaining <= r_remaining - (ADDR_W + 1)'(1);
            end
        end
    end
    // RAM data returns the cycle after issue and lands at the buffer tail
    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (r_inflight) begin
                r_buf[r_wr_ptr] <= q;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop)
                r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
        end
    end
endmodule
